// File: rtl/demux_fifo_umbral_n.sv
// demux_fifo_umbral_n: one push stream is routed by a destination field into
// NUM_CH per-channel FIFOs. Each channel has programmable almost-full and
// almost-empty thresholds, sticky overflow/underflow error flags and a
// registered read port. A RESET/INIT/IDLE/ACTIVE state machine gates access.
//
// Ports:
//   clk, reset        clock (posedge) and asynchronous active-high reset
//   init              threshold-load request (enters/holds INIT)
//   umbral_full/empty almost-full / almost-empty thresholds, latched in INIT
//   data_in, push_data_in  write word and write strobe
//   pop               per-channel read strobe
//   data_out          per-channel registered read data, channel c at [c*DATA_W +: DATA_W]
//   almost_full/empty per-channel threshold flags (from registered counts)
//   pause             OR of almost_full
//   errors, error_out sticky per-channel overflow/underflow and their OR
//   active_out, idle_out  FSM is in ACTIVE / IDLE
module demux_fifo_umbral_n #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned CH_BITS  = 1,
  parameter int unsigned DEST_LSB = 4,
  parameter int unsigned PTR_L    = 2,
  localparam int unsigned NUM_CH  = 1 << CH_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [PTR_L-1:0]           umbral_full,
  input  logic [PTR_L-1:0]           umbral_empty,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       push_data_in,
  input  logic [NUM_CH-1:0]          pop,
  output logic [NUM_CH*DATA_W-1:0]   data_out,
  output logic [NUM_CH-1:0]          almost_full,
  output logic [NUM_CH-1:0]          almost_empty,
  output logic                       pause,
  output logic [NUM_CH-1:0]          errors,
  output logic                       error_out,
  output logic                       active_out,
  output logic                       idle_out
);

  localparam int unsigned DEPTH = 1 << PTR_L;
  localparam int unsigned CNT_W = PTR_L + 1;

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

  state_t                          state_q, state_d;
  logic [PTR_L-1:0]                thr_full_q, thr_full_d;
  logic [PTR_L-1:0]                thr_empty_q, thr_empty_d;
  logic [NUM_CH-1:0][PTR_L-1:0]    wr_ptr_q, wr_ptr_d;
  logic [NUM_CH-1:0][PTR_L-1:0]    rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0][CNT_W-1:0]    count_q, count_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   data_out_q, data_out_d;
  logic [NUM_CH-1:0]               errors_q, errors_d;
  logic [DATA_W-1:0]               mem_q [NUM_CH][DEPTH];
  logic [DATA_W-1:0]               mem_d [NUM_CH][DEPTH];

  logic [CH_BITS-1:0]              dest;
  logic                            io_en;
  logic                            all_empty;
  logic [NUM_CH-1:0]               push_hit, pop_hit, is_full, is_empty;
  logic [NUM_CH-1:0]               do_push, do_pop;

  // Next-state logic; init overrides every other transition.
  always_comb begin
    state_d   = state_q;
    all_empty = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (count_q[c] != '0) all_empty = 1'b0;
    end
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)              state_d = ST_INIT;
        else if (push_data_in) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                            state_d = ST_INIT;
        else if (all_empty && !push_data_in) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // FIFO datapath: routing, pointer/count update, read port and error capture.
  always_comb begin
    thr_full_d  = thr_full_q;
    thr_empty_d = thr_empty_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    errors_d    = errors_q;
    mem_d       = mem_q;
    push_hit    = '0;
    pop_hit     = '0;
    is_full     = '0;
    is_empty    = '0;
    do_push     = '0;
    do_pop      = '0;
    dest        = data_in[DEST_LSB +: CH_BITS];
    io_en       = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

    if (state_q == ST_INIT) begin
      thr_full_d  = umbral_full;
      thr_empty_d = umbral_empty;
      errors_d    = '0;
    end

    for (int c = 0; c < NUM_CH; c++) begin
      push_hit[c] = io_en && push_data_in && (dest == CH_BITS'(c));
      pop_hit[c]  = io_en && pop[c];
      is_full[c]  = (count_q[c] == CNT_W'(DEPTH));
      is_empty[c] = (count_q[c] == '0);
      // A full channel still takes a push when the same cycle frees a slot.
      do_pop[c]   = pop_hit[c] && !is_empty[c];
      do_push[c]  = push_hit[c] && (!is_full[c] || pop_hit[c]);

      if ((push_hit[c] && is_full[c] && !pop_hit[c]) || (pop_hit[c] && is_empty[c]))
        errors_d[c] = 1'b1;

      // Read uses the pre-edge memory, so a full push+pop returns the old word.
      if (do_pop[c]) begin
        data_out_d[c] = mem_q[c][rd_ptr_q[c]];
        rd_ptr_d[c]   = rd_ptr_q[c] + PTR_L'(1);
      end
      if (do_push[c]) begin
        mem_d[c][wr_ptr_q[c]] = data_in;
        wr_ptr_d[c]           = wr_ptr_q[c] + PTR_L'(1);
      end

      unique case ({do_push[c], do_pop[c]})
        2'b10:   count_d[c] = count_q[c] + CNT_W'(1);
        2'b01:   count_d[c] = count_q[c] - CNT_W'(1);
        default: count_d[c] = count_q[c];
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      thr_full_q  <= '1;
      thr_empty_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      errors_q    <= '0;
    end else begin
      state_q     <= state_d;
      thr_full_q  <= thr_full_d;
      thr_empty_q <= thr_empty_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      errors_q    <= errors_d;
    end
  end

  // Storage array; contents are only meaningful behind valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Threshold flags compare the count against the zero-extended threshold.
  always_comb begin
    almost_full  = '0;
    almost_empty = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      almost_full[c]  = (count_q[c] >= {1'b0, thr_full_q});
      almost_empty[c] = (count_q[c] <= {1'b0, thr_empty_q});
    end
  end

  assign data_out   = data_out_q;
  assign pause      = |almost_full;
  assign errors     = errors_q;
  assign error_out  = |errors_q;
  assign active_out = (state_q == ST_ACTIVE);
  assign idle_out   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_demux_fifo_umbral_n.sv
// Bench for demux_fifo_umbral_n (2 channels, depth 4, destination at bit 4).
// A queue-based reference model predicts every output; a compare process
// checks the DUT against it just after each rising edge, and directed
// sequences pin the model with hand-computed literals.
module tb_demux_fifo_umbral_n;

  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b0;
  logic [1:0]  umbral_full = 2'd3;
  logic [1:0]  umbral_empty = 2'd1;
  logic [5:0]  data_in = '0;
  logic        push_data_in = 1'b0;
  logic [1:0]  pop = '0;
  logic [11:0] data_out;
  logic [1:0]  almost_full, almost_empty, errors;
  logic        pause, error_out, active_out, idle_out;

  demux_fifo_umbral_n #(.DATA_W(6), .CH_BITS(1), .DEST_LSB(4), .PTR_L(2)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_full(umbral_full), .umbral_empty(umbral_empty),
    .data_in(data_in), .push_data_in(push_data_in), .pop(pop),
    .data_out(data_out), .almost_full(almost_full), .almost_empty(almost_empty),
    .pause(pause), .errors(errors), .error_out(error_out),
    .active_out(active_out), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef logic [5:0] word_t;
  word_t      mq [2][$];
  word_t      m_dout [2];
  logic [1:0] m_err;
  logic [1:0] m_tf, m_te;
  int         m_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_RESET;
    mq[0].delete();
    mq[1].delete();
    m_dout[0] = '0;
    m_dout[1] = '0;
    m_err = '0;
    m_tf = 2'd3;
    m_te = 2'd0;
  endtask

  // Effect of the next rising edge given the inputs currently driven.
  task automatic model_step();
    int sz [2];
    int nxt;
    bit ph, pp;
    if (reset) return;
    sz[0] = mq[0].size();
    sz[1] = mq[1].size();
    nxt = m_state;
    case (m_state)
      S_RESET:  nxt = S_INIT;
      S_INIT:   nxt = init ? S_INIT : S_IDLE;
      S_IDLE:   nxt = init ? S_INIT : (push_data_in ? S_ACTIVE : S_IDLE);
      default:  nxt = init ? S_INIT :
                      ((sz[0] == 0 && sz[1] == 0 && !push_data_in) ? S_IDLE : S_ACTIVE);
    endcase
    if (m_state == S_INIT) begin
      m_tf  = umbral_full;
      m_te  = umbral_empty;
      m_err = '0;
    end
    if (m_state == S_IDLE || m_state == S_ACTIVE) begin
      for (int c = 0; c < 2; c++) begin
        ph = push_data_in && (int'(data_in[4]) == c);
        pp = pop[c];
        if (pp) begin
          if (sz[c] == 0) m_err[c] = 1'b1;
          else m_dout[c] = mq[c].pop_front();
        end
        if (ph) begin
          if (sz[c] == 4 && !pp) m_err[c] = 1'b1;
          else mq[c].push_back(data_in);
        end
      end
    end
    m_state = nxt;
  endtask

  task automatic compare_all();
    logic [1:0] e_af, e_ae;
    for (int c = 0; c < 2; c++) begin
      e_af[c] = mq[c].size() >= int'(m_tf);
      e_ae[c] = mq[c].size() <= int'(m_te);
    end
    chk("data_out", 64'(data_out), 64'({m_dout[1], m_dout[0]}));
    chk("almost_full", 64'(almost_full), 64'(e_af));
    chk("almost_empty", 64'(almost_empty), 64'(e_ae));
    chk("pause", 64'(pause), 64'(|e_af));
    chk("errors", 64'(errors), 64'(m_err));
    chk("error_out", 64'(error_out), 64'(|m_err));
    chk("active_out", 64'(active_out), 64'(m_state == S_ACTIVE));
    chk("idle_out", 64'(idle_out), 64'(m_state == S_IDLE));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) compare_all();
    end
  end

  // Drive one cycle's inputs at the falling edge, advance the model, wait a cycle.
  task automatic cyc(input logic i, input logic p, input logic [5:0] d, input logic [1:0] po);
    init = i;
    push_data_in = p;
    data_in = d;
    pop = po;
    model_step();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b1;
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    repeat (4) cyc(0, 0, 6'h00, 2'b00);
    reset = 1'b0;

    // Threshold load: full=3, empty=1
    umbral_full = 2'd3;
    umbral_empty = 2'd1;
    cyc(1, 0, 6'h00, 2'b00);
    cyc(1, 0, 6'h00, 2'b00);
    cyc(0, 0, 6'h00, 2'b00);
    chk("init_almost_empty", 64'(almost_empty), 64'h3);
    chk("init_pause", 64'(pause), 64'h0);
    chk("init_idle", 64'(idle_out), 64'h1);
    chk("init_active", 64'(active_out), 64'h0);

    // Fill ch0 and overflow
    cyc(0, 1, 6'h01, 2'b00);
    chk("push1_active", 64'(active_out), 64'h1);
    cyc(0, 1, 6'h02, 2'b00);
    cyc(0, 1, 6'h03, 2'b00);
    chk("push3_af", 64'(almost_full), 64'h1);
    chk("push3_pause", 64'(pause), 64'h1);
    chk("push3_ae", 64'(almost_empty[0]), 64'h0);
    cyc(0, 1, 6'h04, 2'b00);
    chk("push4_noerr", 64'(errors), 64'h0);
    cyc(0, 1, 6'h05, 2'b00);
    chk("ovf_errors", 64'(errors), 64'h1);
    chk("ovf_error_out", 64'(error_out), 64'h1);

    // Drain ch0 plus one underflow
    cyc(0, 0, 6'h00, 2'b01);
    chk("pop1_data", 64'(data_out[5:0]), 64'h01);
    chk("pop1_pause", 64'(pause), 64'h1);
    cyc(0, 0, 6'h00, 2'b01);
    chk("pop2_data", 64'(data_out[5:0]), 64'h02);
    chk("pop2_pause", 64'(pause), 64'h0);
    cyc(0, 0, 6'h00, 2'b01);
    chk("pop3_data", 64'(data_out[5:0]), 64'h03);
    chk("pop3_ae", 64'(almost_empty[0]), 64'h1);
    cyc(0, 0, 6'h00, 2'b01);
    chk("pop4_data", 64'(data_out[5:0]), 64'h04);
    cyc(0, 0, 6'h00, 2'b01);
    chk("udf_hold", 64'(data_out[5:0]), 64'h04);
    chk("udf_idle", 64'(idle_out), 64'h1);
    cyc(1, 0, 6'h00, 2'b00);
    cyc(0, 0, 6'h00, 2'b00);
    chk("clr_errors", 64'(errors), 64'h0);
    chk("clr_idle", 64'(idle_out), 64'h1);

    // Routing across both channels
    cyc(0, 1, 6'h10, 2'b00);
    cyc(0, 1, 6'h00, 2'b00);
    cyc(0, 1, 6'h11, 2'b00);
    cyc(0, 1, 6'h3F, 2'b00);
    cyc(0, 0, 6'h00, 2'b11);
    chk("route_pop_both", 64'(data_out), 64'({6'h10, 6'h00}));
    cyc(0, 0, 6'h00, 2'b10);
    chk("route_ch1_b", 64'(data_out[11:6]), 64'h11);
    cyc(0, 0, 6'h00, 2'b10);
    chk("route_ch1_c", 64'(data_out[11:6]), 64'h3F);
    chk("route_noerr", 64'(errors), 64'h0);

    // Full channel with simultaneous push and pop
    cyc(0, 1, 6'h21, 2'b00);
    cyc(0, 1, 6'h22, 2'b00);
    cyc(0, 1, 6'h23, 2'b00);
    cyc(0, 1, 6'h24, 2'b00);
    cyc(0, 1, 6'h07, 2'b01);
    chk("fullpp_data", 64'(data_out[5:0]), 64'h21);
    chk("fullpp_noerr", 64'(errors), 64'h0);
    chk("fullpp_af", 64'(almost_full[0]), 64'h1);
    cyc(0, 0, 6'h00, 2'b01);
    cyc(0, 0, 6'h00, 2'b01);
    cyc(0, 0, 6'h00, 2'b01);
    cyc(0, 0, 6'h00, 2'b01);
    chk("fullpp_last", 64'(data_out[5:0]), 64'h07);
    chk("fullpp_drain_noerr", 64'(errors), 64'h0);

    // Asynchronous reset with data buffered
    cyc(0, 1, 6'h05, 2'b00);
    cyc(0, 1, 6'h15, 2'b01);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_data_out", 64'(data_out), 64'h0);
    chk("arst_ae", 64'(almost_empty), 64'h3);
    chk("arst_af", 64'(almost_full), 64'h0);
    chk("arst_pause", 64'(pause), 64'h0);
    chk("arst_active", 64'(active_out), 64'h0);
    chk("arst_idle", 64'(idle_out), 64'h0);
    chk("arst_errors", 64'(errors), 64'h0);
    @(negedge clk);
    cyc(0, 0, 6'h00, 2'b00);
    reset = 1'b0;
    cyc(0, 1, 6'h03, 2'b00);
    cyc(0, 1, 6'h13, 2'b00);
    chk("post_rst_ignored", 64'(almost_empty), 64'h3);
    chk("post_rst_idle", 64'(idle_out), 64'h1);
    chk("post_rst_noerr", 64'(errors), 64'h0);
    cyc(0, 1, 6'h03, 2'b00);
    chk("post_rst_active", 64'(active_out), 64'h1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic ri, rp;
      logic [1:0] rpop;
      umbral_full = 2'($urandom_range(0, 3));
      umbral_empty = 2'($urandom_range(0, 3));
      ri = ($urandom_range(0, 99) < 4);
      rp = ($urandom_range(0, 99) < 55);
      rpop[0] = ($urandom_range(0, 99) < 30);
      rpop[1] = ($urandom_range(0, 99) < 30);
      cyc(ri, rp, 6'($urandom), rpop);
    end

    cyc(0, 0, 6'h00, 2'b00);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
